multi_timer: RTL and testbench

- Parametrised N-channel programmable interval timer for the laRVa SoC peripheral bus.
- Each channel has its own MAX (period) register, control register and counter. Each counter is driven by a per-channel prescaler.
- Supports periodic and one-shot modes, a per-channel interrupt enable, write-1-to-clear status flags and a single combined IRQ line.

---
 rtl/multi_timer_pkg.sv | 12 +
 rtl/timer_channel.sv | 85 ++++++++
 rtl/multi_timer.sv | 93 +++++++++
 tb/tb_multi_timer.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/multi_timer_pkg.sv
// Shared register-map and CTRL bit definitions for the multi_timer peripheral.
package multi_timer_pkg;
    localparam logic [1:0] REG_MAX    = 2'd0;
    localparam logic [1:0] REG_CTRL   = 2'd1;
    localparam logic [1:0] REG_COUNT  = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    localparam int CTRL_EN  = 0;
    localparam int CTRL_PER = 1;
    localparam int CTRL_IE  = 2;
    localparam int CTRL_W   = 3;
endpackage

// File: rtl/timer_channel.sv
// One timer channel: MAX/CTRL registers, prescaler, counter and expiry flag.
// Flag lands MAX*PRESC cycles after a MAX/CTRL write; no backpressure. Optional ovf bit under MULTI_TIMER_OVF_EN.
module timer_channel
    import multi_timer_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int PRESC = 18
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_max,
    input  logic              wr_ctrl,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              clr,
`ifdef MULTI_TIMER_OVF_EN
    input  logic              clr_ovf,
    output logic              ovf,
`endif
    output logic [WIDTH-1:0]  max_q,
    output logic [CTRL_W-1:0] ctrl,
    output logic [WIDTH-1:0]  count,
    output logic              flag
);
    localparam int PW = (PRESC > 1) ? $clog2(PRESC) : 1;

    logic [PW-1:0] p;
    logic          wr_any;
    logic          active;
    logic          tick;
    logic          expire;

    assign wr_any = wr_max | wr_ctrl;
    // MAX==0 is treated as idle, so MAX-1 below never wraps
    assign active = ctrl[CTRL_EN] && (max_q != '0);
    assign tick   = active && (p == PW'(PRESC - 1));
    assign expire = tick && (count == max_q - WIDTH'(1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            max_q <= '0;
            ctrl  <= '0;
            count <= '0;
            p     <= '0;
            flag  <= 1'b0;
        end else begin
            if (wr_max)
                max_q <= wdata;

            if (wr_ctrl)
                ctrl <= wdata[CTRL_W-1:0];
            else if (expire && !ctrl[CTRL_PER])
                ctrl[CTRL_EN] <= 1'b0;

            if (wr_any) begin
                p     <= '0;
                count <= '0;
            end else if (active) begin
                p <= tick ? '0 : p + PW'(1);
                if (tick)
                    count <= expire ? '0 : count + WIDTH'(1);
            end

            // Bus write beats expiry; expiry beats W1C
            if (wr_any)
                flag <= 1'b0;
            else if (expire)
                flag <= 1'b1;
            else if (clr)
                flag <= 1'b0;
        end
    end

`ifdef MULTI_TIMER_OVF_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            ovf <= 1'b0;
        else if (wr_any)
            ovf <= 1'b0;
        else if (expire && flag)
            ovf <= 1'b1;
        else if (clr_ovf)
            ovf <= 1'b0;
    end
`endif
endmodule

// File: rtl/multi_timer.sv
// N-channel interval timer: address decode, combinational rdata mux and irq OR over timer_channel instances.
// rdata is combinational from addr, irq is registered with flags; no backpressure. STATUS ovf bits under MULTI_TIMER_OVF_EN.
module multi_timer
    import multi_timer_pkg::*;
#(
    parameter  int NCH   = 4,
    parameter  int WIDTH = 32,
    parameter  int PRESC = 18,
    localparam int AW    = $clog2(NCH) + 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr,
    input  logic             rd,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [NCH-1:0]   flags,
    output logic             irq
);
    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

    logic [1:0]        reg_sel;
    logic [CW-1:0]     ch_sel;
    logic [WIDTH-1:0]  max_q [NCH];
    logic [CTRL_W-1:0] ctrl  [NCH];
    logic [WIDTH-1:0]  count [NCH];
    logic [NCH-1:0]    ie;
    logic [WIDTH-1:0]  status_word;
    logic              unused_rd;

    // Reads are side-effect free; rd is kept only for bus compatibility
    assign unused_rd = rd;
    assign reg_sel   = addr[1:0];

    generate
        if (NCH > 1) begin : g_sel
            assign ch_sel = addr[AW-1:2];
        end else begin : g_sel1
            assign ch_sel = '0;
        end
    endgenerate

`ifdef MULTI_TIMER_OVF_EN
    logic [NCH-1:0] ovf;
    assign status_word = WIDTH'({ovf, flags});
`else
    assign status_word = WIDTH'(flags);
`endif

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        timer_channel #(
            .WIDTH (WIDTH),
            .PRESC (PRESC)
        ) u_ch (
            .clk     (clk),
            .reset   (reset),
            .wr_max  (wr && reg_sel == REG_MAX  && ch_sel == CW'(g)),
            .wr_ctrl (wr && reg_sel == REG_CTRL && ch_sel == CW'(g)),
            .wdata   (wdata),
            .clr     (wr && reg_sel == REG_STATUS && wdata[g]),
`ifdef MULTI_TIMER_OVF_EN
            .clr_ovf (wr && reg_sel == REG_STATUS && wdata[NCH+g]),
            .ovf     (ovf[g]),
`endif
            .max_q   (max_q[g]),
            .ctrl    (ctrl[g]),
            .count   (count[g]),
            .flag    (flags[g])
        );
        assign ie[g] = ctrl[g][CTRL_IE];
    end

    assign irq = |(flags & ie);

    always_comb begin
        rdata = '0;
        if (reg_sel == REG_STATUS) begin
            rdata = status_word;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (ch_sel == CW'(i)) begin
                    case (reg_sel)
                        REG_MAX:   rdata = max_q[i];
                        REG_CTRL:  rdata = WIDTH'(ctrl[i]);
                        REG_COUNT: rdata = count[i];
                        default:   rdata = '0;
                    endcase
                end
            end
        end
    end
endmodule

// File: tb/tb_multi_timer.sv
// Directed bench for multi_timer with NCH=4, WIDTH=32, PRESC=4.
module tb_multi_timer;
    localparam int NCH   = 4;
    localparam int WIDTH = 32;
    localparam int PRESC = 4;
    localparam int AW    = 4;
`ifdef MULTI_TIMER_OVF_EN
    localparam logic [31:0] OVF_STATUS = 32'h11;
`else
    localparam logic [31:0] OVF_STATUS = 32'h01;
`endif

    logic             clk   = 1'b0;
    logic             reset = 1'b1;
    logic             wr    = 1'b0;
    logic             rd    = 1'b0;
    logic [AW-1:0]    addr  = '0;
    logic [WIDTH-1:0] wdata = '0;
    logic [WIDTH-1:0] rdata;
    logic [NCH-1:0]   flags;
    logic             irq;

    int n_run  = 0;
    int n_fail = 0;
    logic [31:0] d;

    multi_timer #(.NCH(NCH), .WIDTH(WIDTH), .PRESC(PRESC)) dut (
        .clk   (clk),
        .reset (reset),
        .wr    (wr),
        .rd    (rd),
        .addr  (addr),
        .wdata (wdata),
        .rdata (rdata),
        .flags (flags),
        .irq   (irq)
    );

    always #5 clk = ~clk;

    function automatic logic [AW-1:0] ad(input int ch, input logic [1:0] r);
        return {2'(ch), r};
    endfunction

    // Write registers on the next posedge; returns 1 time unit after that edge
    task automatic bus_write(input logic [AW-1:0] a, input logic [31:0] v);
        @(negedge clk);
        wr = 1'b1; addr = a; wdata = v;
        @(posedge clk);
        #1;
        wr = 1'b0;
    endtask

    task automatic bus_read(input logic [AW-1:0] a, output logic [31:0] v);
        addr = a; rd = 1'b1;
        #1;
        v = rdata; rd = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        #2;
        n_run++; if (flags !== 4'h0) begin n_fail++; $display("FAIL reset_flags got %0h exp 0", flags); end
        n_run++; if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq got %0b exp 0", irq); end
        bus_read(ad(0, 2'd0), d);
        n_run++; if (d !== 32'h0) begin n_fail++; $display("FAIL reset_max0 got %0h exp 0", d); end
        bus_read(ad(1, 2'd1), d);
        n_run++; if (d !== 32'h0) begin n_fail++; $display("FAIL reset_ctrl1 got %0h exp 0", d); end
        bus_read(ad(3, 2'd2), d);
        n_run++; if (d !== 32'h0) begin n_fail++; $display("FAIL reset_count3 got %0h exp 0", d); end
        bus_read(ad(2, 2'd3), d);
        n_run++; if (d !== 32'h0) begin n_fail++; $display("FAIL reset_status got %0h exp 0", d); end
        @(negedge clk);
        reset = 1'b0;
        wait_cycles(2);
    endtask

    task automatic test_periodic_w1c;
        bus_write(ad(0, 2'd0), 32'd3);
        bus_write(ad(0, 2'd1), 32'b011);           // E0
        bus_read(ad(0, 2'd2), d);
        n_run++; if (d !== 32'd0) begin n_fail++; $display("FAIL per_count_e0 got %0d exp 0", d); end
        wait_cycles(3);                             // E3
        bus_read(ad(0, 2'd2), d);
        n_run++; if (d !== 32'd0) begin n_fail++; $display("FAIL per_count_e3 got %0d exp 0", d); end
        wait_cycles(1);                             // E4
        bus_read(ad(0, 2'd2), d);
        n_run++; if (d !== 32'd1) begin n_fail++; $display("FAIL per_count_e4 got %0d exp 1", d); end
        wait_cycles(4);                             // E8
        bus_read(ad(0, 2'd2), d);
        n_run++; if (d !== 32'd2) begin n_fail++; $display("FAIL per_count_e8 got %0d exp 2", d); end
        wait_cycles(3);                             // E11
        n_run++; if (flags[0] !== 1'b0) begin n_fail++; $display("FAIL per_flag_e11 got %0b exp 0", flags[0]); end
        wait_cycles(1);                             // E12
        n_run++; if (flags[0] !== 1'b1) begin n_fail++; $display("FAIL per_flag_e12 got %0b exp 1", flags[0]); end
        n_run++; if (irq !== 1'b0) begin n_fail++; $display("FAIL per_irq_noie got %0b exp 0", irq); end
        bus_read(ad(0, 2'd2), d);
        n_run++; if (d !== 32'd0) begin n_fail++; $display("FAIL per_count_wrap got %0d exp 0", d); end
        bus_write(ad(0, 2'd3), 32'h1);              // E13
        n_run++; if (flags[0] !== 1'b0) begin n_fail++; $display("FAIL w1c_clear got %0b exp 0", flags[0]); end
        wait_cycles(10);                            // E23
        n_run++; if (flags[0] !== 1'b0) begin n_fail++; $display("FAIL per_flag_e23 got %0b exp 0", flags[0]); end
        wait_cycles(1);                             // E24
        n_run++; if (flags[0] !== 1'b1) begin n_fail++; $display("FAIL per_flag_e24 got %0b exp 1", flags[0]); end
        bus_write(ad(0, 2'd3), 32'h1);              // E25
        wait_cycles(10);                            // E35
        n_run++; if (flags[0] !== 1'b0) begin n_fail++; $display("FAIL per_flag_e35 got %0b exp 0", flags[0]); end
        bus_write(ad(0, 2'd3), 32'h1);              // W1C on expiry edge E36
        n_run++; if (flags[0] !== 1'b1) begin n_fail++; $display("FAIL w1c_vs_set got %0b exp 1", flags[0]); end
        bus_write(ad(0, 2'd3), 32'h1);              // E37
        n_run++; if (flags[0] !== 1'b0) begin n_fail++; $display("FAIL w1c_late got %0b exp 0", flags[0]); end
        n_run++; if (irq !== 1'b0) begin n_fail++; $display("FAIL w1c_irq got %0b exp 0", irq); end
        bus_write(ad(0, 2'd1), 32'h0);
    endtask

    task automatic test_oneshot;
        bus_write(ad(1, 2'd0), 32'd2);
        bus_write(ad(1, 2'd1), 32'b101);           // E0
        wait_cycles(7);
        n_run++; if (flags[1] !== 1'b0 || irq !== 1'b0) begin n_fail++; $display("FAIL os_e7 got flag=%0b irq=%0b exp 0/0", flags[1], irq); end
        wait_cycles(1);
        n_run++; if (flags[1] !== 1'b1) begin n_fail++; $display("FAIL os_flag_e8 got %0b exp 1", flags[1]); end
        n_run++; if (irq !== 1'b1) begin n_fail++; $display("FAIL os_irq_e8 got %0b exp 1", irq); end
        bus_read(ad(1, 2'd1), d);
        n_run++; if (d !== 32'b100) begin n_fail++; $display("FAIL os_ctrl got %0h exp 4", d); end
        bus_write(ad(1, 2'd3), 32'h2);
        wait_cycles(20);
        bus_read(ad(1, 2'd2), d);
        n_run++; if (d !== 32'd0) begin n_fail++; $display("FAIL os_count_hold got %0d exp 0", d); end
        n_run++; if (flags !== 4'h0 || irq !== 1'b0) begin n_fail++; $display("FAIL os_no_refire got flags=%0h irq=%0b exp 0/0", flags, irq); end
    endtask

    task automatic test_idle_rewrite;
        bus_write(ad(2, 2'd1), 32'b001);
        wait_cycles(100);
        bus_read(ad(2, 2'd2), d);
        n_run++; if (d !== 32'd0) begin n_fail++; $display("FAIL idle_count got %0d exp 0", d); end
        n_run++; if (flags[2] !== 1'b0) begin n_fail++; $display("FAIL idle_flag got %0b exp 0", flags[2]); end
        bus_read(ad(2, 2'd1), d);
        n_run++; if (d !== 32'd1) begin n_fail++; $display("FAIL idle_ctrl got %0h exp 1", d); end
        bus_write(ad(2, 2'd0), 32'd3);              // E0
        wait_cycles(6);
        bus_read(ad(2, 2'd2), d);
        n_run++; if (d !== 32'd1) begin n_fail++; $display("FAIL rw_count_mid got %0d exp 1", d); end
        bus_write(ad(2, 2'd0), 32'd3);              // restart edge
        bus_read(ad(2, 2'd2), d);
        n_run++; if (d !== 32'd0) begin n_fail++; $display("FAIL rw_count_restart got %0d exp 0", d); end
        wait_cycles(11);
        n_run++; if (flags[2] !== 1'b0) begin n_fail++; $display("FAIL rw_flag_early got %0b exp 0", flags[2]); end
        wait_cycles(1);
        n_run++; if (flags[2] !== 1'b1) begin n_fail++; $display("FAIL rw_flag_12 got %0b exp 1", flags[2]); end
        bus_write(ad(2, 2'd1), 32'h0);
        n_run++; if (flags !== 4'h0) begin n_fail++; $display("FAIL rw_ctrl_clears got %0h exp 0", flags); end
    endtask

    task automatic test_status_ovf;
        bus_write(ad(0, 2'd0), 32'd1);
        bus_write(ad(0, 2'd1), 32'b011);           // E0
        wait_cycles(7);
        bus_read(ad(3, 2'd3), d);
        n_run++; if (d !== 32'h01) begin n_fail++; $display("FAIL st_e7 got %0h exp 1", d); end
        wait_cycles(1);
        bus_read(ad(1, 2'd3), d);
        n_run++; if (d !== OVF_STATUS) begin n_fail++; $display("FAIL st_ovf got %0h exp %0h", d, OVF_STATUS); end
        bus_write(ad(0, 2'd3), 32'h10);
        bus_read(ad(0, 2'd3), d);
        n_run++; if (d !== 32'h01) begin n_fail++; $display("FAIL st_w1c_ovf got %0h exp 1", d); end
        bus_write(ad(0, 2'd1), 32'h0);
        bus_read(ad(0, 2'd3), d);
        n_run++; if (d !== 32'h0) begin n_fail++; $display("FAIL st_ctrl_clear got %0h exp 0", d); end
    endtask

    task automatic test_reset_mid;
        bus_write(ad(1, 2'd0), 32'd1);
        bus_write(ad(3, 2'd0), 32'd3);
        bus_write(ad(3, 2'd1), 32'b011);           // E0
        bus_write(ad(1, 2'd1), 32'b101);           // E1, ch1 fires at E5
        wait_cycles(4);                             // E5
        bus_read(ad(3, 2'd2), d);
        n_run++; if (d !== 32'd1) begin n_fail++; $display("FAIL rm_count_pre got %0d exp 1", d); end
        n_run++; if (irq !== 1'b1) begin n_fail++; $display("FAIL rm_irq_pre got %0b exp 1", irq); end
        reset = 1'b1;
        #1;
        n_run++; if (flags !== 4'h0 || irq !== 1'b0) begin n_fail++; $display("FAIL rm_async got flags=%0h irq=%0b exp 0/0", flags, irq); end
        bus_read(ad(3, 2'd2), d);
        n_run++; if (d !== 32'd0) begin n_fail++; $display("FAIL rm_count got %0d exp 0", d); end
        bus_read(ad(3, 2'd0), d);
        n_run++; if (d !== 32'd0) begin n_fail++; $display("FAIL rm_max got %0d exp 0", d); end
        @(negedge clk);
        reset = 1'b0;
        wait_cycles(30);
        n_run++; if (flags !== 4'h0 || irq !== 1'b0) begin n_fail++; $display("FAIL rm_post got flags=%0h irq=%0b exp 0/0", flags, irq); end
        bus_read(ad(3, 2'd2), d);
        n_run++; if (d !== 32'd0) begin n_fail++; $display("FAIL rm_post_count got %0d exp 0", d); end
    endtask

    initial begin
        test_reset();
        test_periodic_w1c();
        test_oneshot();
        test_idle_rewrite();
        test_status_ovf();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
